// File: rtl/pc_seq_defs.sv
// Shared definitions for the next-PC sequencer: sequencer state encoding,
// redirect priority codes and default address/width constants.
package pc_seq_defs;

  localparam int          PC_W_DEF      = 16;
  localparam logic [15:0] RESET_VEC_DEF = 16'h0000;
  localparam logic [15:0] IRQ_VEC_DEF   = 16'h0004;
  localparam int          PC_STEP_DEF   = 1;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_WRITE0 = 3'd1,
    ST_FETCH  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_STALL  = 3'd4
  } seq_state_t;

  // Numeric order is the overwrite priority: a larger code replaces a smaller one.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_BR   = 2'd1,
    RD_JMP  = 2'd2,
    RD_RETI = 2'd3
  } redirect_kind_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer (master)
// and the instruction memory (slave).
interface pc_sequencer_if import pc_seq_defs::*; #(
  parameter int PC_W = PC_W_DEF
);

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack
  );

endinterface

// File: rtl/redirect_latch.sv
// Single-entry pending redirect register. Holds the strongest branch, jump
// or return-from-interrupt seen since the last decision; equal priority
// keeps the newest event.
module redirect_latch import pc_seq_defs::*; #(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            clear,
  input  logic            in_isr,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            reti,
  output redirect_kind_t  pend_kind,
  output logic [PC_W-1:0] pend_target
);

  redirect_kind_t  in_kind;
  logic [PC_W-1:0] in_target;

  // Reduce this cycle's redirect inputs to the single strongest event; reti only counts inside a handler.
  always_comb begin
    in_kind   = RD_NONE;
    in_target = '0;
    if (reti && in_isr) begin
      in_kind = RD_RETI;
    end else if (jmp_valid) begin
      in_kind   = RD_JMP;
      in_target = jmp_target;
    end else if (br_taken) begin
      in_kind   = RD_BR;
      in_target = br_target;
    end
  end

  // Load a new event if it is at least as strong as the pending one; a decision empties the entry first.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_kind   <= RD_NONE;
      pend_target <= '0;
    end else if (enable && (in_kind != RD_NONE) && (clear || (in_kind >= pend_kind))) begin
      pend_kind   <= in_kind;
      pend_target <= in_target;
    end else if (clear) begin
      pend_kind   <= RD_NONE;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: boots the PC register, fetches through a req/ack
// handshake and, on each completed fetch, writes the next PC chosen by
// priority irq > reti > jump > branch > sequential. Tracks the interrupt
// return address and whether a handler is running.
module pc_sequencer import pc_seq_defs::*; #(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
  parameter logic [PC_W-1:0] IRQ_VEC   = PC_W'(IRQ_VEC_DEF),
  parameter int              PC_STEP   = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_cur,
  pc_sequencer_if.master  imem,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            irq,
  input  logic            reti,
  output logic            pc_write,
  output logic [PC_W-1:0] pc_in,
  output logic            fetch_valid,
  output logic            flush,
  output logic [PC_W-1:0] epc,
  output logic            in_isr
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  seq_state_t      state;
  logic            req_q;
  logic            decide;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] tgt_pc;
  redirect_kind_t  pend_kind;
  logic [PC_W-1:0] pend_target;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_cur;

  // The decision point is the cycle a fetch completes; the sequential PC wraps at the width boundary.
  always_comb begin
    decide = (state == ST_FETCH) && imem.imem_ack;
    seq_pc = pc_cur + STEP;
    tgt_pc = (pend_kind != RD_NONE) ? pend_target : seq_pc;
  end

  redirect_latch #(.PC_W(PC_W)) u_redirect (
    .clk         (clk),
    .reset       (reset),
    .enable      (state != ST_BOOT),
    .clear       (decide),
    .in_isr      (in_isr),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp_valid   (jmp_valid),
    .jmp_target  (jmp_target),
    .reti        (reti),
    .pend_kind   (pend_kind),
    .pend_target (pend_target)
  );

  // Sequencer FSM with registered outputs; the pulse outputs default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_BOOT;
      req_q       <= 1'b0;
      pc_write    <= 1'b0;
      pc_in       <= '0;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      epc         <= '0;
      in_isr      <= 1'b0;
    end else begin
      pc_write    <= 1'b0;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      unique case (state)
        ST_BOOT: begin
          state    <= ST_WRITE0;
          pc_write <= 1'b1;
          pc_in    <= RESET_VEC;
        end
        ST_WRITE0: begin
          state <= ST_FETCH;
          req_q <= 1'b1;
        end
        ST_FETCH: begin
          if (imem.imem_ack) begin
            state    <= ST_UPDATE;
            req_q    <= 1'b0;
            pc_write <= 1'b1;
            if (irq && !in_isr) begin
              pc_in  <= IRQ_VEC;
              epc    <= tgt_pc;
              in_isr <= 1'b1;
              flush  <= 1'b1;
            end else if (pend_kind == RD_RETI) begin
              pc_in  <= epc;
              in_isr <= 1'b0;
              flush  <= 1'b1;
            end else if (pend_kind != RD_NONE) begin
              pc_in <= pend_target;
              flush <= 1'b1;
            end else begin
              pc_in       <= seq_pc;
              fetch_valid <= 1'b1;
            end
          end
        end
        ST_UPDATE: begin
          if (stall) begin
            state <= ST_STALL;
          end else begin
            state <= ST_FETCH;
            req_q <= 1'b1;
          end
        end
        ST_STALL: begin
          if (!stall) begin
            state <= ST_FETCH;
            req_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_BOOT;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. A behavioural PC register and an
// instruction memory that acks one cycle after seeing a request surround the
// DUT; expected PC writes are queued when stimulus is driven and compared
// when the DUT pulses pc_write.
module tb_pc_sequencer;
  import pc_seq_defs::*;

  localparam int W = 16;
  localparam logic [W-1:0] RST_VEC = 16'h0000;
  localparam logic [W-1:0] IRQ_V   = 16'h0004;

  typedef struct packed {
    logic [W-1:0] pc;
    logic         fv;
    logic         fl;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] pc_cur;
  logic         stall = 1'b0;
  logic         br_taken = 1'b0;
  logic [W-1:0] br_target = '0;
  logic         jmp_valid = 1'b0;
  logic [W-1:0] jmp_target = '0;
  logic         irq = 1'b0;
  logic         reti = 1'b0;
  logic         pc_write;
  logic [W-1:0] pc_in;
  logic         fetch_valid;
  logic         flush;
  logic [W-1:0] epc;
  logic         in_isr;

  logic ack_en = 1'b1;
  logic man_ack = 1'b0;
  logic mem_ack;
  int   cyc = 0;

  int           n_cmp = 0;
  int           n_fail = 0;
  exp_t         sb[$];
  logic [W-1:0] exp_pc = '0;
  logic [W-1:0] exp_epc = '0;

  pc_sequencer_if #(.PC_W(W)) bus ();

  pc_sequencer #(.PC_W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_cur      (pc_cur),
    .imem        (bus.master),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp_valid   (jmp_valid),
    .jmp_target  (jmp_target),
    .irq         (irq),
    .reti        (reti),
    .pc_write    (pc_write),
    .pc_in       (pc_in),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .epc         (epc),
    .in_isr      (in_isr)
  );

  always #5 clk = ~clk;

  // PC register fed by the sequencer
  always @(posedge clk) begin
    if (reset) pc_cur <= '0;
    else if (pc_write) pc_cur <= pc_in;
  end

  // Instruction memory: one-cycle ack pulse the cycle after it sees a request
  always @(posedge clk) begin
    if (reset) mem_ack <= 1'b0;
    else mem_ack <= ack_en && bus.imem_req && !mem_ack;
  end

  assign bus.imem_ack = mem_ack | man_ack;

  // Free-running cycle counter used for write-cadence checks
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_seq();
    exp_pc = exp_pc + 16'd1;
    sb.push_back('{pc: exp_pc, fv: 1'b1, fl: 1'b0});
  endfunction

  function automatic void expect_redirect(input logic [W-1:0] v);
    exp_pc = v;
    sb.push_back('{pc: v, fv: 1'b0, fl: 1'b1});
  endfunction

  task automatic wait_write();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!pc_write && k < 40);
    if (!pc_write) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL write_timeout: pc_write=%b after %0d cycles, required 1", pc_write, k);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    int   last;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.imem_req, pc_write, fetch_valid, flush, in_isr} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: req/wr/fv/fl/isr=%b required 00000",
               {bus.imem_req, pc_write, fetch_valid, flush, in_isr});
    end
    n_cmp++;
    if (epc !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL reset_epc: got %h required 0000", epc);
    end
    reset = 1'b0;
    exp_pc = RST_VEC;
    sb.push_back('{pc: RST_VEC, fv: 1'b0, fl: 1'b0});
    expect_seq();
    expect_seq();
    expect_seq();
    last = 0;
    for (int i = 0; i < 4; i++) begin
      wait_write();
      e = sb.pop_front();
      n_cmp++;
      if ({pc_in, fetch_valid, flush} !== {e.pc, e.fv, e.fl}) begin
        n_fail++;
        $display("[TB] FAIL boot_seq[%0d]: pc_in=%h fv=%b fl=%b required %h %b %b",
                 i, pc_in, fetch_valid, flush, e.pc, e.fv, e.fl);
      end
      if (i > 0) begin
        n_cmp++;
        if (cyc - last !== 3) begin
          n_fail++;
          $display("[TB] FAIL write_period[%0d]: got %0d cycles required 3", i, cyc - last);
        end
      end
      last = cyc;
    end
  endtask

  task automatic test_branch();
    exp_t e;
    @(negedge clk);
    br_taken = 1'b1;
    br_target = 16'h0040;
    expect_redirect(16'h0040);
    @(negedge clk);
    br_taken = 1'b0;
    wait_write();
    e = sb.pop_front();
    n_cmp++;
    if ({pc_in, fetch_valid, flush} !== {e.pc, e.fv, e.fl}) begin
      n_fail++;
      $display("[TB] FAIL branch: pc_in=%h fv=%b fl=%b required %h %b %b",
               pc_in, fetch_valid, flush, e.pc, e.fv, e.fl);
    end
    expect_seq();
    wait_write();
    e = sb.pop_front();
    n_cmp++;
    if ({pc_in, fetch_valid, flush} !== {e.pc, e.fv, e.fl}) begin
      n_fail++;
      $display("[TB] FAIL branch_seq: pc_in=%h fv=%b fl=%b required %h %b %b",
               pc_in, fetch_valid, flush, e.pc, e.fv, e.fl);
    end
  endtask

  task automatic test_jmp_br_priority();
    exp_t e;
    jmp_valid = 1'b1;
    jmp_target = 16'h0100;
    br_taken = 1'b1;
    br_target = 16'h0200;
    expect_redirect(16'h0100);
    @(negedge clk);
    jmp_valid = 1'b0;
    br_taken = 1'b0;
    wait_write();
    e = sb.pop_front();
    n_cmp++;
    if ({pc_in, fetch_valid, flush} !== {e.pc, e.fv, e.fl}) begin
      n_fail++;
      $display("[TB] FAIL same_cycle_jmp_br: pc_in=%h fv=%b fl=%b required %h %b %b",
               pc_in, fetch_valid, flush, e.pc, e.fv, e.fl);
    end
    jmp_valid = 1'b1;
    jmp_target = 16'h0300;
    @(negedge clk);
    jmp_valid = 1'b0;
    br_taken = 1'b1;
    br_target = 16'h0500;
    expect_redirect(16'h0300);
    @(negedge clk);
    br_taken = 1'b0;
    wait_write();
    e = sb.pop_front();
    n_cmp++;
    if ({pc_in, fetch_valid, flush} !== {e.pc, e.fv, e.fl}) begin
      n_fail++;
      $display("[TB] FAIL br_after_jmp: pc_in=%h fv=%b fl=%b required %h %b %b",
               pc_in, fetch_valid, flush, e.pc, e.fv, e.fl);
    end
    br_taken = 1'b1;
    br_target = 16'h0600;
    @(negedge clk);
    br_target = 16'h0700;
    expect_redirect(16'h0700);
    @(negedge clk);
    br_taken = 1'b0;
    wait_write();
    e = sb.pop_front();
    n_cmp++;
    if ({pc_in, fetch_valid, flush} !== {e.pc, e.fv, e.fl}) begin
      n_fail++;
      $display("[TB] FAIL br_newest_wins: pc_in=%h fv=%b fl=%b required %h %b %b",
               pc_in, fetch_valid, flush, e.pc, e.fv, e.fl);
    end
  endtask

  task automatic test_irq_reti();
    exp_t e;
    jmp_valid = 1'b1;
    jmp_target = 16'h0010;
    expect_redirect(16'h0010);
    @(negedge clk);
    jmp_valid = 1'b0;
    wait_write();
    e = sb.pop_front();
    n_cmp++;
    if ({pc_in, fetch_valid, flush} !== {e.pc, e.fv, e.fl}) begin
      n_fail++;
      $display("[TB] FAIL jmp_0010: pc_in=%h fv=%b fl=%b required %h %b %b",
               pc_in, fetch_valid, flush, e.pc, e.fv, e.fl);
    end
    irq = 1'b1;
    exp_epc = exp_pc + 16'd1;
    expect_redirect(IRQ_V);
    wait_write();
    e = sb.pop_front();
    n_cmp++;
    if ({pc_in, fetch_valid, flush} !== {e.pc, e.fv, e.fl}) begin
      n_fail++;
      $display("[TB] FAIL irq_entry: pc_in=%h fv=%b fl=%b required %h %b %b",
               pc_in, fetch_valid, flush, e.pc, e.fv, e.fl);
    end
    n_cmp++;
    if ({in_isr, epc} !== {1'b1, exp_epc}) begin
      n_fail++;
      $display("[TB] FAIL irq_epc: in_isr=%b epc=%h required 1 %h", in_isr, epc, exp_epc);
    end
    expect_seq();
    wait_write();
    e = sb.pop_front();
    n_cmp++;
    if ({pc_in, fetch_valid, flush} !== {e.pc, e.fv, e.fl}) begin
      n_fail++;
      $display("[TB] FAIL nested_irq: pc_in=%h fv=%b fl=%b required %h %b %b",
               pc_in, fetch_valid, flush, e.pc, e.fv, e.fl);
    end
    n_cmp++;
    if ({in_isr, epc} !== {1'b1, exp_epc}) begin
      n_fail++;
      $display("[TB] FAIL nested_epc: in_isr=%b epc=%h required 1 %h", in_isr, epc, exp_epc);
    end
    irq = 1'b0;
    reti = 1'b1;
    expect_redirect(exp_epc);
    @(negedge clk);
    reti = 1'b0;
    wait_write();
    e = sb.pop_front();
    n_cmp++;
    if ({pc_in, fetch_valid, flush, in_isr} !== {e.pc, e.fv, e.fl, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reti: pc_in=%h fv=%b fl=%b isr=%b required %h %b %b 0",
               pc_in, fetch_valid, flush, in_isr, e.pc, e.fv, e.fl);
    end
    expect_seq();
    wait_write();
    e = sb.pop_front();
    n_cmp++;
    if ({pc_in, fetch_valid, flush} !== {e.pc, e.fv, e.fl}) begin
      n_fail++;
      $display("[TB] FAIL after_reti: pc_in=%h fv=%b fl=%b required %h %b %b",
               pc_in, fetch_valid, flush, e.pc, e.fv, e.fl);
    end
  endtask

  task automatic test_wrap_and_stray_reti();
    exp_t e;
    jmp_valid = 1'b1;
    jmp_target = 16'hFFFF;
    expect_redirect(16'hFFFF);
    @(negedge clk);
    jmp_valid = 1'b0;
    wait_write();
    e = sb.pop_front();
    n_cmp++;
    if ({pc_in, fetch_valid, flush} !== {e.pc, e.fv, e.fl}) begin
      n_fail++;
      $display("[TB] FAIL jmp_ffff: pc_in=%h fv=%b fl=%b required %h %b %b",
               pc_in, fetch_valid, flush, e.pc, e.fv, e.fl);
    end
    expect_seq();
    wait_write();
    e = sb.pop_front();
    n_cmp++;
    if ({pc_in, fetch_valid, flush} !== {e.pc, e.fv, e.fl}) begin
      n_fail++;
      $display("[TB] FAIL wrap: pc_in=%h fv=%b fl=%b required %h %b %b",
               pc_in, fetch_valid, flush, e.pc, e.fv, e.fl);
    end
    reti = 1'b1;
    expect_seq();
    @(negedge clk);
    reti = 1'b0;
    wait_write();
    e = sb.pop_front();
    n_cmp++;
    if ({pc_in, fetch_valid, flush, in_isr} !== {e.pc, e.fv, e.fl, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL stray_reti: pc_in=%h fv=%b fl=%b isr=%b required %h %b %b 0",
               pc_in, fetch_valid, flush, in_isr, e.pc, e.fv, e.fl);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    stall = 1'b1;
    n_cmp++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stall_update_req: got %b required 0", bus.imem_req);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) stall = 1'b0;
      n_cmp++;
      if ({bus.imem_req, pc_write} !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL stall_hold[%0d]: req/wr=%b required 00", i, {bus.imem_req, pc_write});
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.imem_req !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL stall_release_req: got %b required 1", bus.imem_req);
    end
    expect_seq();
    wait_write();
    e = sb.pop_front();
    n_cmp++;
    if ({pc_in, fetch_valid, flush} !== {e.pc, e.fv, e.fl}) begin
      n_fail++;
      $display("[TB] FAIL after_stall: pc_in=%h fv=%b fl=%b required %h %b %b",
               pc_in, fetch_valid, flush, e.pc, e.fv, e.fl);
    end
  endtask

  task automatic test_reset_mid_fetch();
    exp_t e;
    br_taken = 1'b1;
    br_target = 16'h0777;
    @(negedge clk);
    br_taken = 1'b0;
    ack_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.imem_req, pc_write, in_isr, epc} !== {3'b000, 16'h0000}) begin
      n_fail++;
      $display("[TB] FAIL midreset_state: req/wr/isr=%b epc=%h required 000 0000",
               {bus.imem_req, pc_write, in_isr}, epc);
    end
    reset = 1'b0;
    man_ack = 1'b1;
    exp_pc = RST_VEC;
    sb.push_back('{pc: RST_VEC, fv: 1'b0, fl: 1'b0});
    @(negedge clk);
    man_ack = 1'b0;
    ack_en = 1'b1;
    e = sb.pop_front();
    n_cmp++;
    if ({pc_write, pc_in, fetch_valid, flush} !== {1'b1, e.pc, e.fv, e.fl}) begin
      n_fail++;
      $display("[TB] FAIL boot_ack_ignored: wr=%b pc_in=%h fv=%b fl=%b required 1 %h %b %b",
               pc_write, pc_in, fetch_valid, flush, e.pc, e.fv, e.fl);
    end
    expect_seq();
    wait_write();
    e = sb.pop_front();
    n_cmp++;
    if ({pc_in, fetch_valid, flush} !== {e.pc, e.fv, e.fl}) begin
      n_fail++;
      $display("[TB] FAIL pending_cleared: pc_in=%h fv=%b fl=%b required %h %b %b",
               pc_in, fetch_valid, flush, e.pc, e.fv, e.fl);
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_branch();
    test_jmp_br_priority();
    test_irq_reti();
    test_wrap_and_stray_reti();
    test_stall();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard stop in case the scenario sequence ever stops making progress
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
